// File: rtl/video_sram_port_arbiter_if.sv
// Request/grant/read-return bundle for one requester of the video SRAM arbiter.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface video_sram_port_arbiter_if #(
    parameter int unsigned AddrW = 10
);
    logic             req;
    logic             we;
    logic [AddrW-1:0] addr;
    logic [3:0]       wmask;
    logic [31:0]      wdata;
    logic             gnt;
    logic             rvalid;
    logic [31:0]      rdata;

    modport master (
        output req, we, addr, wmask, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wmask, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/video_sram_port_arbiter.sv
// Shares one SRAM rw port (two 32-bit macros) between CPU port A and video port B.
// B wins by default; A wins once it has been refused MAX_WAIT cycles. Reads return 2 cycles after grant.
module video_sram_port_arbiter #(
    parameter int unsigned SRAM_ADDRESS_SIZE = 9,
    parameter int unsigned MAX_WAIT          = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    video_sram_port_arbiter_if.slave     a_io,
    video_sram_port_arbiter_if.slave     b_io,
    output logic [1:0]                   sram_csb0_o,
    output logic                         sram_web0_o,
    output logic [3:0]                   sram_wmask0_o,
    output logic [SRAM_ADDRESS_SIZE-1:0] sram_addr0_o,
    output logic [31:0]                  sram_din0_o,
    input  logic [63:0]                  sram_dout0_i
);
    localparam int unsigned      WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    logic [WaitW-1:0]             wait_q, wait_d;
    logic                         a_gnt, b_gnt, any_gnt, starve;
    logic                         iss_we;
    logic [SRAM_ADDRESS_SIZE:0]   iss_addr;
    logic [3:0]                   iss_wmask;
    logic [31:0]                  iss_wdata;
    logic [1:0]                   csb_q, csb_d;
    logic                         web_q, web_d;
    logic [3:0]                   wmask_q, wmask_d;
    logic [SRAM_ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [31:0]                  din_q, din_d;
    logic                         s1_valid_q, s1_port_q, s1_sel_q;
    logic                         s2_valid_q, s2_port_q, s2_sel_q;
    logic                         a_rvalid, b_rvalid;
    logic [31:0]                  rd_word, a_rdata_q, b_rdata_q;

    always_comb begin
        starve  = a_io.req & (wait_q == WaitMax);
        b_gnt   = rst_ni & b_io.req & ~starve;
        a_gnt   = rst_ni & a_io.req & ~b_gnt;
        any_gnt = a_gnt | b_gnt;
    end

    // Counts consecutive refused cycles of a pending A request.
    always_comb begin
        wait_d = '0;
        if (a_io.req && !a_gnt) begin
            wait_d = (wait_q == WaitMax) ? wait_q : wait_q + 1'b1;
        end
    end

    always_comb begin
        iss_we    = b_gnt ? b_io.we    : a_io.we;
        iss_addr  = b_gnt ? b_io.addr  : a_io.addr;
        iss_wmask = b_gnt ? b_io.wmask : a_io.wmask;
        iss_wdata = b_gnt ? b_io.wdata : a_io.wdata;
        csb_d     = 2'b11;
        web_d     = 1'b1;
        wmask_d   = wmask_q;
        addr_d    = addr_q;
        din_d     = din_q;
        if (any_gnt) begin
            csb_d   = iss_addr[SRAM_ADDRESS_SIZE] ? 2'b01 : 2'b10;
            web_d   = ~iss_we;
            wmask_d = iss_wmask;
            addr_d  = iss_addr[SRAM_ADDRESS_SIZE-1:0];
            din_d   = iss_wdata;
        end
    end

    assign rd_word  = s2_sel_q ? sram_dout0_i[63:32] : sram_dout0_i[31:0];
    assign a_rvalid = s2_valid_q & ~s2_port_q;
    assign b_rvalid = s2_valid_q & s2_port_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wait_q     <= '0;
            csb_q      <= 2'b11;
            web_q      <= 1'b1;
            wmask_q    <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s1_sel_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
            s2_sel_q   <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            wait_q     <= wait_d;
            csb_q      <= csb_d;
            web_q      <= web_d;
            wmask_q    <= wmask_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            // Stage 1 follows the SRAM pins, stage 2 the SRAM sampling edge.
            s1_valid_q <= any_gnt & ~iss_we;
            s1_port_q  <= b_gnt;
            s1_sel_q   <= iss_addr[SRAM_ADDRESS_SIZE];
            s2_valid_q <= s1_valid_q;
            s2_port_q  <= s1_port_q;
            s2_sel_q   <= s1_sel_q;
            if (a_rvalid) a_rdata_q <= rd_word;
            if (b_rvalid) b_rdata_q <= rd_word;
        end
    end

    assign sram_csb0_o   = csb_q;
    assign sram_web0_o   = web_q;
    assign sram_wmask0_o = wmask_q;
    assign sram_addr0_o  = addr_q;
    assign sram_din0_o   = din_q;

    assign a_io.gnt    = a_gnt;
    assign a_io.rvalid = a_rvalid;
    assign a_io.rdata  = a_rvalid ? rd_word : a_rdata_q;
    assign b_io.gnt    = b_gnt;
    assign b_io.rvalid = b_rvalid;
    assign b_io.rdata  = b_rvalid ? rd_word : b_rdata_q;
endmodule

// File: tb/tb_video_sram_port_arbiter.sv
// Bench for video_sram_port_arbiter: behavioural SRAM bank pair plus a cycle-level reference
// model (word-addressed memory, starvation count, queue of expected read returns).
module tb_video_sram_port_arbiter;
    localparam int unsigned AW      = 9;
    localparam int          MaxWait = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_sram_port_arbiter_if #(.AddrW(AW + 1)) a_if ();
    video_sram_port_arbiter_if #(.AddrW(AW + 1)) b_if ();

    logic [1:0]    csb;
    logic          web;
    logic [3:0]    wmask;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic [63:0]   dout;

    video_sram_port_arbiter #(
        .SRAM_ADDRESS_SIZE(AW),
        .MAX_WAIT         (MaxWait)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .a_io         (a_if),
        .b_io         (b_if),
        .sram_csb0_o  (csb),
        .sram_web0_o  (web),
        .sram_wmask0_o(wmask),
        .sram_addr0_o (addr),
        .sram_din0_o  (din),
        .sram_dout0_i (dout)
    );

    function automatic logic [31:0] apply_mask(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] m);
        apply_mask = old;
        for (int b = 0; b < 4; b++) if (m[b]) apply_mask[8*b +: 8] = d[8*b +: 8];
    endfunction

    // Two SRAM macros, index {macro, row}; read data registered at the sampling edge.
    logic [31:0] sram_mem [1024];
    logic [31:0] dout_q   [2];
    assign dout = {dout_q[1], dout_q[0]};
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!csb[m]) begin
                if (!web) sram_mem[{m[0], addr}] <= apply_mask(sram_mem[{m[0], addr}], din, wmask);
                else      dout_q[m] <= sram_mem[{m[0], addr}];
            end
        end
    end

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rd_t;

    rd_t           rdq[$];
    logic [31:0]   ref_mem [1024];
    int            cyc, m_wait;
    logic [1:0]    m_csb;
    logic          m_web;
    logic [3:0]    m_wmask;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_din, m_last_a, m_last_b;
    int            n_checks, n_fail;
    int            a_gnt_cnt, a_rv_cnt;
    logic [31:0]   last_rd_a, last_rd_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rdq.delete();
        m_wait   = 0;
        m_csb    = 2'b11;
        m_web    = 1'b1;
        m_wmask  = '0;
        m_addr   = '0;
        m_din    = '0;
        m_last_a = '0;
        m_last_b = '0;
    endtask

    task automatic drive_a(input bit req, input bit we, input logic [AW:0] ad,
                           input logic [3:0] m, input logic [31:0] d);
        a_if.req = req; a_if.we = we; a_if.addr = ad; a_if.wmask = m; a_if.wdata = d;
    endtask

    task automatic drive_b(input bit req, input bit we, input logic [AW:0] ad,
                           input logic [3:0] m, input logic [31:0] d);
        b_if.req = req; b_if.we = we; b_if.addr = ad; b_if.wmask = m; b_if.wdata = d;
    endtask

    // Inputs are already applied; check this cycle at the falling edge, then advance the model.
    task automatic cycle();
        bit          ea, eb, rva, rvb, wwe;
        logic [AW:0] wa;
        logic [3:0]  wm;
        logic [31:0] wd;
        @(negedge clk);
        eb = rst_n && b_if.req && !(a_if.req && m_wait >= MaxWait);
        ea = rst_n && a_if.req && !eb;
        check_eq("a_gnt", a_if.gnt, ea);
        check_eq("b_gnt", b_if.gnt, eb);
        check_eq("one_gnt", a_if.gnt & b_if.gnt, 0);
        check_eq("csb", csb, m_csb);
        check_eq("web", web, m_web);
        check_eq("wmask", wmask, m_wmask);
        check_eq("addr", addr, m_addr);
        check_eq("din", din, m_din);
        rva = rdq.size() > 0 && rdq[0].due == cyc && !rdq[0].port;
        rvb = rdq.size() > 0 && rdq[0].due == cyc && rdq[0].port;
        check_eq("a_rvalid", a_if.rvalid, rva);
        check_eq("b_rvalid", b_if.rvalid, rvb);
        check_eq("a_rdata", a_if.rdata, rva ? rdq[0].data : m_last_a);
        check_eq("b_rdata", b_if.rdata, rvb ? rdq[0].data : m_last_b);
        if (a_if.rvalid) begin last_rd_a = a_if.rdata; a_rv_cnt++; end
        if (b_if.rvalid) last_rd_b = b_if.rdata;
        if (a_if.gnt) a_gnt_cnt++;
        if (rva) m_last_a = rdq[0].data;
        if (rvb) m_last_b = rdq[0].data;
        if (rva || rvb) void'(rdq.pop_front());
        if (!rst_n) begin
            model_reset();
        end else begin
            if (ea || eb) begin
                wwe = eb ? b_if.we : a_if.we;
                wa  = eb ? b_if.addr : a_if.addr;
                wm  = eb ? b_if.wmask : a_if.wmask;
                wd  = eb ? b_if.wdata : a_if.wdata;
                m_csb   = wa[AW] ? 2'b01 : 2'b10;
                m_web   = !wwe;
                m_wmask = wm;
                m_addr  = wa[AW-1:0];
                m_din   = wd;
                if (wwe) ref_mem[wa] = apply_mask(ref_mem[wa], wd, wm);
                else     rdq.push_back('{cyc + 2, eb, ref_mem[wa]});
            end else begin
                m_csb = 2'b11;
                m_web = 1'b1;
            end
            if (a_if.req && !ea) m_wait = (m_wait < MaxWait) ? m_wait + 1 : MaxWait;
            else                 m_wait = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_a(0, 0, '0, '0, '0);
        drive_b(0, 0, '0, '0, '0);
        repeat (n) cycle();
    endtask

    logic [AW:0] t5_addr [4];

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            sram_mem[i] = v;
            ref_mem[i]  = v;
        end
        sram_mem[10'h3FF] = 32'hFFFF_FFFF;
        ref_mem[10'h3FF]  = 32'hFFFF_FFFF;
        n_checks = 0; n_fail = 0; cyc = 0;
        drive_a(0, 0, '0, '0, '0);
        drive_b(0, 0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // 1: reset with both requests high
        drive_a(1, 0, 10'h001, 4'hF, 32'h0);
        drive_b(1, 0, 10'h201, 4'hF, 32'h0);
        repeat (2) cycle();
        check_eq("t1_csb", csb, 2'b11);
        rst_n = 1'b1;
        idle(2);

        // 2: A write then A read on macro 0
        last_rd_a = '0;
        drive_a(1, 1, 10'h005, 4'hF, 32'hDEAD_BEEF);
        cycle();
        check_eq("t2_csb_wr", csb, 2'b10);
        drive_a(1, 0, 10'h005, 4'h0, 32'h0);
        cycle();
        check_eq("t2_csb_rd", csb, 2'b10);
        idle(3);
        check_eq("t2_rdata", last_rd_a, 32'hDEAD_BEEF);

        // 3: B masked write then read on macro 1
        last_rd_b = '0;
        drive_b(1, 1, 10'h3FF, 4'h3, 32'h1234_5678);
        cycle();
        check_eq("t3_csb_wr", csb, 2'b01);
        drive_b(1, 0, 10'h3FF, 4'h0, 32'h0);
        cycle();
        idle(3);
        check_eq("t3_rdata", last_rd_b, 32'hFFFF_5678);

        // 4: both ports held, A must win once every MaxWait+1 cycles
        a_gnt_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive_a(1, 0, 10'($urandom), 4'h0, 32'h0);
            drive_b(1, 0, 10'($urandom), 4'h0, 32'h0);
            cycle();
        end
        check_eq("t4_a_grants", a_gnt_cnt, 2);
        idle(3);

        // 5: alternating A/B reads back-to-back
        t5_addr[0] = 10'h010; t5_addr[1] = 10'h210; t5_addr[2] = 10'h005; t5_addr[3] = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                drive_a(1, 0, t5_addr[i], 4'h0, 32'h0);
                drive_b(0, 0, '0, '0, '0);
            end else begin
                drive_a(0, 0, '0, '0, '0);
                drive_b(1, 0, t5_addr[i], 4'h0, 32'h0);
            end
            cycle();
        end
        idle(3);
        check_eq("t5_last_b", last_rd_b, 32'hFFFF_5678);

        // 6: reset right after an A read grant discards the read
        drive_a(1, 0, 10'h005, 4'h0, 32'h0);
        cycle();
        drive_a(0, 0, '0, '0, '0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        a_rv_cnt = 0;
        idle(3);
        check_eq("t6_no_rvalid", a_rv_cnt, 0);
        last_rd_a = '0;
        drive_a(1, 0, 10'h005, 4'h0, 32'h0);
        cycle();
        idle(3);
        check_eq("t6_rdata", last_rd_a, 32'hDEAD_BEEF);

        // 7: random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 10'($urandom),
                    4'($urandom), $urandom);
            drive_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 10'($urandom),
                    4'($urandom), $urandom);
            cycle();
        end
        rst_n = 1'b1;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
